// File: rtl/serial_clkgen.sv
// Multi-channel programmable clock divider with shadowed configuration,
// a common counter-zero alignment point and a settle timer that drives locked.
module serial_clkgen #(
   parameter int NUM_CLOCKS  = 2,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 5,
   parameter int LOCK_CYCLES = 16,
   parameter int CH_W        = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [CH_W-1:0]       cfg_ch,
   input  logic [DIV_W-1:0]      cfg_div,
   input  logic [DIV_W-1:0]      cfg_phase,
   output logic [NUM_CLOCKS-1:0] clk_en,
   output logic [NUM_CLOCKS-1:0] clk_out,
   output logic                  locked
);

   localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CH_W:0] NUM_CH = (CH_W+1)'(NUM_CLOCKS);

   typedef enum logic [1:0] {RESET_ST, APPLY, SETTLE, LOCKED} state_t;

   state_t             state;
   logic [SET_W-1:0]   settle_cnt;
   logic [DIV_W-1:0]   shadow_div [NUM_CLOCKS];
   logic [DIV_W-1:0]   shadow_ph  [NUM_CLOCKS];
   logic [DIV_W-1:0]   active_div [NUM_CLOCKS];
   logic [DIV_W-1:0]   active_ph  [NUM_CLOCKS];
   logic [DIV_W-1:0]   cnt        [NUM_CLOCKS];
   logic [DIV_W-1:0]   eff_div    [NUM_CLOCKS];
   logic [DIV_W-1:0]   eff_ph     [NUM_CLOCKS];
   logic [DIV_W:0]     high_len   [NUM_CLOCKS];
   logic               running;
   logic               wr_ok;

   assign running   = (state == SETTLE) || (state == LOCKED);
   assign cfg_ready = running;
   assign locked    = (state == LOCKED);
   assign wr_ok     = cfg_valid && cfg_ready && ({1'b0, cfg_ch} < NUM_CH);

   // Ratios 0 and 1 both mean "every cycle"; phase is clamped into the period.
   always_comb begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
         eff_div[i]  = (active_div[i] <= DIV_W'(1)) ? DIV_W'(1) : active_div[i];
         eff_ph[i]   = (active_ph[i] > eff_div[i] - DIV_W'(1)) ? eff_div[i] - DIV_W'(1)
                                                               : active_ph[i];
         high_len[i] = ({1'b0, eff_div[i]} + (DIV_W+1)'(1)) >> 1;
         clk_en[i]   = running && (cnt[i] == eff_ph[i]);
         clk_out[i]  = running && ({1'b0, cnt[i]} < high_len[i]);
      end
   end

   always_ff @(posedge refclk) begin
      if (!rst) begin
         state      <= RESET_ST;
         settle_cnt <= '0;
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            shadow_div[i] <= DIV_W'(DEFAULT_DIV);
            shadow_ph[i]  <= '0;
            active_div[i] <= DIV_W'(DEFAULT_DIV);
            active_ph[i]  <= '0;
            cnt[i]        <= '0;
         end
      end else begin
         case (state)
            RESET_ST: state <= APPLY;
            // All channels restart together so their counter-zero cycles line up.
            APPLY: begin
               for (int i = 0; i < NUM_CLOCKS; i++) begin
                  active_div[i] <= shadow_div[i];
                  active_ph[i]  <= shadow_ph[i];
                  cnt[i]        <= '0;
               end
               settle_cnt <= '0;
               state      <= SETTLE;
            end
            SETTLE, LOCKED: begin
               for (int i = 0; i < NUM_CLOCKS; i++)
                  cnt[i] <= (cnt[i] == eff_div[i] - DIV_W'(1)) ? '0 : cnt[i] + DIV_W'(1);
               if (state == SETTLE) begin
                  if (settle_cnt == SET_W'(LOCK_CYCLES - 1))
                     state <= LOCKED;
                  else
                     settle_cnt <= settle_cnt + SET_W'(1);
               end
               if (wr_ok) begin
                  state <= APPLY;
                  for (int i = 0; i < NUM_CLOCKS; i++) begin
                     if (cfg_ch == CH_W'(i)) begin
                        shadow_div[i] <= cfg_div;
                        shadow_ph[i]  <= cfg_phase;
                     end
                  end
               end
            end
            default: state <= RESET_ST;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_clkgen.sv
// Self-checking bench for serial_clkgen: directed scenarios plus random traffic
// compared each cycle against a time-since-apply reference model.
module tb_serial_clkgen;

   // Three channels so that cfg_ch is two bits wide and index 3 is out of range.
   localparam int NCH = 3;
   localparam int LCK = 16;
   localparam int DEF = 5;

   logic       refclk = 1'b0;
   logic       rst;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [1:0] cfg_ch;
   logic [7:0] cfg_div;
   logic [7:0] cfg_phase;
   logic [2:0] clk_en;
   logic [2:0] clk_out;
   logic       locked;

   int checks = 0;
   int errors = 0;

   int m_mode;
   int m_n;
   int m_sdiv [NCH];
   int m_sph  [NCH];
   int m_adiv [NCH];
   int m_aph  [NCH];

   serial_clkgen #(.NUM_CLOCKS(NCH), .DIV_W(8), .DEFAULT_DIV(DEF), .LOCK_CYCLES(LCK)) dut (
      .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
      .clk_en(clk_en), .clk_out(clk_out), .locked(locked)
   );

   always #5 refclk = ~refclk;

   // Model: mode 0 = in reset, 1 = applying, 2 = running for m_n cycles since counters zeroed.
   function automatic void model_edge(input logic r, input logic v, input int ch, input int d, input int p);
      if (!r) begin
         m_mode = 0;
         m_n    = 0;
         for (int i = 0; i < NCH; i++) begin
            m_sdiv[i] = DEF; m_sph[i] = 0; m_adiv[i] = DEF; m_aph[i] = 0;
         end
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         m_mode = 2;
         m_n    = 0;
         for (int i = 0; i < NCH; i++) begin
            m_adiv[i] = m_sdiv[i]; m_aph[i] = m_sph[i];
         end
      end else if (v && ch < NCH) begin
         m_sdiv[ch] = d;
         m_sph[ch]  = p;
         m_mode     = 1;
      end else begin
         m_n++;
      end
   endfunction

   function automatic logic [7:0] model_out();
      logic [2:0] en;
      logic [2:0] hi;
      int d, p, c;
      en = '0;
      hi = '0;
      if (m_mode != 2) return 8'd0;
      for (int i = 0; i < NCH; i++) begin
         d = (m_adiv[i] <= 1) ? 1 : m_adiv[i];
         p = (m_aph[i] > d - 1) ? d - 1 : m_aph[i];
         c = m_n % d;
         en[i] = (c == p);
         hi[i] = (c < (d + 1) / 2);
      end
      return {en, hi, (m_n >= LCK), 1'b1};
   endfunction

   task automatic tick();
      @(posedge refclk);
      model_edge(rst, cfg_valid, int'(cfg_ch), int'(cfg_div), int'(cfg_phase));
      #1;
   endtask

   task automatic do_write(input int ch, input int d, input int p);
      int guard = 0;
      while (m_mode != 2 && guard < 8) begin
         tick();
         guard++;
      end
      checks++;
      if (m_mode != 2) begin
         errors++;
         $display("[TB] FAIL write_wait: got mode %0d expected 2", m_mode);
      end
      cfg_valid = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_div   = 8'(d);
      cfg_phase = 8'(p);
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] exp;
      rst = 1'b0;
      cfg_valid = 1'b1;
      cfg_ch = 2'd1; cfg_div = 8'd9; cfg_phase = 8'd2;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if ({clk_en, clk_out, locked, cfg_ready} !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_hold: got %b expected %b", {clk_en, clk_out, locked, cfg_ready}, 8'd0);
         end
      end
      rst = 1'b1;
      cfg_valid = 1'b0;
      tick();
      exp = model_out();
      checks++;
      if ({clk_en, clk_out, locked, cfg_ready} !== 8'd0 || exp !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_release: got %b model %b expected 0", {clk_en, clk_out, locked, cfg_ready}, exp);
      end
   endtask

   task automatic test_defaults();
      logic [7:0] exp;
      int first_lock = -1;
      int en_cnt = 0;
      int hi_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         exp = model_out();
         checks++;
         if ({clk_en, clk_out, locked, cfg_ready} !== exp) begin
            errors++;
            $display("[TB] FAIL defaults k=%0d: got %b expected %b", k, {clk_en, clk_out, locked, cfg_ready}, exp);
         end
         if (locked === 1'b1 && first_lock < 0) first_lock = k;
         if (k < 20 && clk_en[0] === 1'b1) en_cnt++;
         if (k < 20 && clk_out[0] === 1'b1) hi_cnt++;
      end
      checks += 3;
      if (first_lock != LCK) begin
         errors++;
         $display("[TB] FAIL defaults_lock: got %0d expected %0d", first_lock, LCK);
      end
      if (en_cnt != 4) begin
         errors++;
         $display("[TB] FAIL defaults_en_rate: got %0d expected 4", en_cnt);
      end
      if (hi_cnt != 12) begin
         errors++;
         $display("[TB] FAIL defaults_duty: got %0d expected 12", hi_cnt);
      end
   endtask

   task automatic test_reconfig();
      logic [7:0] exp;
      int first_lock = -1;
      do_write(1, 10, 3);
      checks++;
      if ({clk_en, clk_out, locked, cfg_ready} !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reconfig_apply: got %b expected %b", {clk_en, clk_out, locked, cfg_ready}, 8'd0);
      end
      for (int k = 0; k < 40; k++) begin
         tick();
         exp = model_out();
         checks++;
         if ({clk_en, clk_out, locked, cfg_ready} !== exp || clk_en[1] !== (k % 10 == 3)) begin
            errors++;
            $display("[TB] FAIL reconfig k=%0d: got %b expected %b", k, {clk_en, clk_out, locked, cfg_ready}, exp);
         end
         if (locked === 1'b1 && first_lock < 0) first_lock = k;
      end
      checks++;
      if (first_lock != LCK) begin
         errors++;
         $display("[TB] FAIL reconfig_lock: got %0d expected %0d", first_lock, LCK);
      end
   endtask

   task automatic test_div01_clamp();
      logic [7:0] exp;
      do_write(0, 0, 7);
      do_write(1, 1, 7);
      do_write(2, 4, 9);
      for (int k = 0; k < 30; k++) begin
         tick();
         exp = model_out();
         checks++;
         if ({clk_en, clk_out, locked, cfg_ready} !== exp || clk_en[1:0] !== 2'b11 ||
             clk_out[1:0] !== 2'b11 || clk_en[2] !== (k % 4 == 3)) begin
            errors++;
            $display("[TB] FAIL div01_clamp k=%0d: got %b expected %b", k, {clk_en, clk_out, locked, cfg_ready}, exp);
         end
      end
   endtask

   task automatic test_settle_restart();
      logic [7:0] exp;
      int first_lock = -1;
      do_write(0, 6, 2);
      for (int k = 0; k < 11; k++) begin
         tick();
         exp = model_out();
         checks++;
         if ({clk_en, clk_out, locked, cfg_ready} !== exp) begin
            errors++;
            $display("[TB] FAIL settle_pre k=%0d: got %b expected %b", k, {clk_en, clk_out, locked, cfg_ready}, exp);
         end
      end
      do_write(1, 7, 1);
      for (int k = 0; k < 30; k++) begin
         tick();
         exp = model_out();
         checks++;
         if ({clk_en, clk_out, locked, cfg_ready} !== exp) begin
            errors++;
            $display("[TB] FAIL settle_restart k=%0d: got %b expected %b", k, {clk_en, clk_out, locked, cfg_ready}, exp);
         end
         if (locked === 1'b1 && first_lock < 0) first_lock = k;
      end
      checks++;
      if (first_lock != LCK) begin
         errors++;
         $display("[TB] FAIL settle_restart_lock: got %0d expected %0d", first_lock, LCK);
      end
   endtask

   task automatic test_bad_channel();
      logic [7:0] exp;
      do_write(3, 2, 1);
      for (int k = 0; k < 20; k++) begin
         exp = model_out();
         checks++;
         if ({clk_en, clk_out, locked, cfg_ready} !== exp || locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bad_channel k=%0d: got %b expected %b", k, {clk_en, clk_out, locked, cfg_ready}, exp);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_settle();
      logic [7:0] exp;
      do_write(0, 9, 4);
      for (int k = 0; k < 6; k++) tick();
      rst = 1'b0;
      cfg_valid = 1'b1;
      cfg_ch = 2'd1; cfg_div = 8'd2; cfg_phase = 8'd1;
      tick();
      checks++;
      if ({clk_en, clk_out, locked, cfg_ready} !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid: got %b expected %b", {clk_en, clk_out, locked, cfg_ready}, 8'd0);
      end
      rst = 1'b1;
      cfg_valid = 1'b0;
      tick();
      for (int k = 0; k < 30; k++) begin
         tick();
         exp = model_out();
         checks++;
         if ({clk_en, clk_out, locked, cfg_ready} !== exp || clk_en !== ((k % DEF == 0) ? 3'b111 : 3'b000)) begin
            errors++;
            $display("[TB] FAIL reset_defaults k=%0d: got %b expected %b", k, {clk_en, clk_out, locked, cfg_ready}, exp);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] exp;
      for (int k = 0; k < 600; k++) begin
         rst       = ($urandom_range(0, 149) != 0);
         cfg_valid = ($urandom_range(0, 24) == 0);
         cfg_ch    = 2'($urandom_range(0, 3));
         cfg_div   = 8'($urandom_range(0, 12));
         cfg_phase = 8'($urandom_range(0, 15));
         tick();
         exp = model_out();
         checks++;
         if ({clk_en, clk_out, locked, cfg_ready} !== exp) begin
            errors++;
            $display("[TB] FAIL random k=%0d: got %b expected %b", k, {clk_en, clk_out, locked, cfg_ready}, exp);
         end
      end
      rst = 1'b1;
      cfg_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
      m_mode = 0; m_n = 0;
      for (int i = 0; i < NCH; i++) begin
         m_sdiv[i] = DEF; m_sph[i] = 0; m_adiv[i] = DEF; m_aph[i] = 0;
      end
      test_reset();
      test_defaults();
      test_reconfig();
      test_div01_clamp();
      test_settle_restart();
      test_bad_channel();
      test_reset_mid_settle();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
